// File: rtl/clk_fail_monitor_if.sv
// ---------------------------------------------------------------------------
// clk_fail_monitor_if
//   Control/status bundle between software-facing logic and the clock
//   failover monitor.
//
//   auto_en_i    : enables automatic failover to clock 1
//   force_en_i   : force mode, takes priority over auto mode
//   force_sel_i  : forced selection, 0 = clock 0, 1 = clock 1
//   sel_o        : registered mux select, 1 = clock 1
//   clk0_ok_o    : clock 0 judged healthy
//   clk1_ok_o    : clock 1 judged healthy
//   switch_evt_o : one-cycle pulse in the cycle sel_o changes
//   state_o      : FSM state, 0 USE0, 1 USE1, 2 HOLD
//
//   master drives the requests and observes status; slave is the monitor.
// ---------------------------------------------------------------------------
interface clk_fail_monitor_if;
  logic       auto_en_i;
  logic       force_en_i;
  logic       force_sel_i;
  logic       sel_o;
  logic       clk0_ok_o;
  logic       clk1_ok_o;
  logic       switch_evt_o;
  logic [1:0] state_o;

  modport master (
    output auto_en_i, force_en_i, force_sel_i,
    input  sel_o, clk0_ok_o, clk1_ok_o, switch_evt_o, state_o
  );

  modport slave (
    input  auto_en_i, force_en_i, force_sel_i,
    output sel_o, clk0_ok_o, clk1_ok_o, switch_evt_o, state_o
  );
endinterface

// File: rtl/clk_fail_monitor.sv
// ---------------------------------------------------------------------------
// clk_fail_monitor
//   Watchdog and failover controller running on a free-running reference
//   clock. It measures activity of two candidate clocks via divide-by-2
//   toggle signals from their domains, qualifies each clock as ok/failed
//   over fixed measurement windows, and produces the registered clock-select
//   bit for the downstream glitch-free mux. Every switch is followed by a
//   holdoff period during which the selection is frozen.
//
//   clk_i        : free-running reference clock
//   arst_i       : asynchronous reset, active-high (sync release upstream)
//   mon0_tgl_i   : toggle from the clock-0 domain, asynchronous to clk_i
//   mon1_tgl_i   : toggle from the clock-1 domain, asynchronous to clk_i
//   ctrl         : control/status bundle (slave side), see
//                  clk_fail_monitor_if
// ---------------------------------------------------------------------------
module clk_fail_monitor #(
  parameter int WIN_CYCLES   = 1024,
  parameter int MIN_EDGES    = 16,
  parameter int LOCK_WINDOWS = 4,
  parameter int HOLDOFF      = 256,
  parameter int CNT_W        = 16
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                mon0_tgl_i,
  input  logic                mon1_tgl_i,
  clk_fail_monitor_if.slave   ctrl
);

  typedef enum logic [1:0] {
    USE0 = 2'd0,
    USE1 = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int STRK_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [STRK_W-1:0] LOCK_CNT  = STRK_W'(LOCK_WINDOWS);
  localparam logic [STRK_W-1:0] STRK_ONE  = STRK_W'(1);

  logic [1:0]       tgl_raw;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       sync3_q;
  logic [1:0]       edge_seen;
  logic [1:0]       clk_ok;

  logic [CNT_W-1:0] win_cnt_q;
  logic             win_end;

  state_t           state_q;
  state_t           state_d;
  logic             sel_q;
  logic             sel_d;
  logic             evt_q;
  logic             evt_d;
  logic [CNT_W-1:0] holdoff_q;
  logic [CNT_W-1:0] holdoff_d;
  logic             want_switch;

  assign tgl_raw   = {mon1_tgl_i, mon0_tgl_i};
  assign edge_seen = sync2_q ^ sync3_q;
  assign win_end   = (win_cnt_q == WIN_LAST);

  // Two-flop synchroniser per toggle plus a delay flop; comparing the last
  // two stages detects both rising and falling transitions of the toggle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= tgl_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Free-running window counter shared by both clocks; the terminal count
  // cycle marks the window boundary.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      win_cnt_q <= '0;
    end else if (win_end) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + CNT_ONE;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gen_mon
    logic [CNT_W-1:0]  edge_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_inc;
    logic [STRK_W-1:0] streak_q;
    logic              ok_q;
    logic              win_good;

    // The judged count includes an edge landing in the boundary cycle itself,
    // so it is taken from the would-be incremented value.
    assign edge_cnt_inc = (edge_seen[g] && (edge_cnt_q != CNT_MAX)) ?
                          (edge_cnt_q + CNT_ONE) : edge_cnt_q;
    assign win_good     = (edge_cnt_inc >= MIN_CNT);
    assign clk_ok[g]    = ok_q;

    // Edge counting and health qualification: a bad window drops ok and
    // restarts the streak; ok rises once LOCK_WINDOWS good windows in a row
    // have been seen. The counter reloads to zero at every boundary.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        edge_cnt_q <= '0;
        streak_q   <= '0;
        ok_q       <= 1'b0;
      end else if (win_end) begin
        edge_cnt_q <= '0;
        if (win_good) begin
          if (streak_q != LOCK_CNT) begin
            streak_q <= streak_q + STRK_ONE;
          end
          if (streak_q >= (LOCK_CNT - STRK_ONE)) begin
            ok_q <= 1'b1;
          end
        end else begin
          streak_q <= '0;
          ok_q     <= 1'b0;
        end
      end else begin
        edge_cnt_q <= edge_cnt_inc;
      end
    end
  end

  // Failover FSM state register; sel, pulse and holdoff all update together
  // so a switch is one atomic registered event.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= USE0;
      sel_q     <= 1'b0;
      evt_q     <= 1'b0;
      holdoff_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      evt_q     <= evt_d;
      holdoff_q <= holdoff_d;
    end
  end

  // Next-state logic. Force beats auto; auto only moves away from a failed
  // clock toward a healthy one, so there is no automatic revert to clock 0
  // while clock 1 stays ok. HOLD ignores every request until the holdoff
  // expires, after which a still-pending request is acted on immediately.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    evt_d       = 1'b0;
    holdoff_d   = holdoff_q;
    want_switch = 1'b0;

    case (state_q)
      USE0: begin
        if (ctrl.force_en_i) begin
          want_switch = ctrl.force_sel_i;
        end else if (ctrl.auto_en_i && !clk_ok[0] && clk_ok[1]) begin
          want_switch = 1'b1;
        end
      end
      USE1: begin
        if (ctrl.force_en_i) begin
          want_switch = !ctrl.force_sel_i;
        end else if (ctrl.auto_en_i && !clk_ok[1] && clk_ok[0]) begin
          want_switch = 1'b1;
        end
      end
      HOLD: begin
        holdoff_d = holdoff_q - CNT_ONE;
        if (holdoff_q <= CNT_ONE) begin
          state_d = sel_q ? USE1 : USE0;
        end
      end
      default: begin
        state_d = USE0;
      end
    endcase

    if (want_switch) begin
      sel_d     = !sel_q;
      evt_d     = 1'b1;
      holdoff_d = HOLD_LOAD;
      state_d   = HOLD;
    end
  end

  assign ctrl.sel_o        = sel_q;
  assign ctrl.clk0_ok_o    = clk_ok[0];
  assign ctrl.clk1_ok_o    = clk_ok[1];
  assign ctrl.switch_evt_o = evt_q;
  assign ctrl.state_o      = state_q;

endmodule

// File: tb/tb_clk_fail_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_fail_monitor
//   Scoreboard bench for clk_fail_monitor. A reference model, driven by the
//   same stimulus, predicts the DUT outputs for every reference clock cycle
//   and queues them; a monitor pops one prediction per cycle and compares it
//   with the DUT. The model reasons in terms of input history, per-window
//   edge totals, a list of window verdicts and switch timestamps.
// ---------------------------------------------------------------------------
module tb_clk_fail_monitor;

  localparam int WIN     = 64;
  localparam int MINE    = 8;
  localparam int LOCK    = 2;
  localparam int HOLDOFF = 16;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic       sel;
    logic       ok0;
    logic       ok1;
    logic       evt;
    logic [1:0] st;
  } exp_t;

  logic       clk_i;
  logic       arst_i;
  logic [1:0] mon_tgl;

  clk_fail_monitor_if bus ();

  clk_fail_monitor #(
    .WIN_CYCLES   (WIN),
    .MIN_EDGES    (MINE),
    .LOCK_WINDOWS (LOCK),
    .HOLDOFF      (HOLDOFF),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .mon0_tgl_i (mon_tgl[0]),
    .mon1_tgl_i (mon_tgl[1]),
    .ctrl       (bus.slave)
  );

  int   num_checks = 0;
  int   num_errors = 0;
  exp_t exp_q[$];

  int   tgl_mode [2];
  int   tgl_per  [2];
  int   tgl_ph   [2];

  bit   hist0 [$];
  bit   hist1 [$];
  bit   good0 [$];
  bit   good1 [$];
  int   m_cycle;
  int   m_last_sw;
  bit   m_sel;
  bit   m_ok0;
  bit   m_ok1;

  // Free-running reference clock, 10 time units per period.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic bit hist_at(int c, int idx);
    if (idx < 0) return 1'b0;
    return (c == 0) ? hist0[idx] : hist1[idx];
  endfunction

  // An input change seen at clock edge j is counted 3 edges later, so the
  // edge counted at edge j compares the samples taken at j-2 and j-3.
  function automatic int window_edges(int c, int last);
    int n = 0;
    for (int j = last - WIN + 1; j <= last; j++) begin
      if (hist_at(c, j - 2) != hist_at(c, j - 3)) n++;
    end
    if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
    return n;
  endfunction

  // A clock is ok when the most recent LOCK window verdicts are all good.
  function automatic bit recent_all_good(int c);
    int n = (c == 0) ? good0.size() : good1.size();
    if (n < LOCK) return 1'b0;
    for (int i = n - LOCK; i < n; i++) begin
      if (!((c == 0) ? good0[i] : good1[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: one prediction per reference clock edge.
  initial begin
    exp_t e;
    bit   want;
    bit   evt;
    forever begin
      @(posedge clk_i);
      if (arst_i) begin
        hist0.delete();
        hist1.delete();
        good0.delete();
        good1.delete();
        m_cycle   = 0;
        m_last_sw = -100000;
        m_sel     = 1'b0;
        m_ok0     = 1'b0;
        m_ok1     = 1'b0;
        e         = '0;
        exp_q.push_back(e);
      end else begin
        hist0.push_back(mon_tgl[0]);
        hist1.push_back(mon_tgl[1]);
        evt  = 1'b0;
        want = m_sel;
        if (m_cycle > m_last_sw + HOLDOFF) begin
          if (bus.force_en_i) begin
            want = bus.force_sel_i;
          end else if (bus.auto_en_i) begin
            if (!m_sel && !m_ok0 && m_ok1) want = 1'b1;
            if (m_sel && !m_ok1 && m_ok0) want = 1'b0;
          end
          if (want != m_sel) begin
            m_sel     = want;
            evt       = 1'b1;
            m_last_sw = m_cycle;
          end
        end
        if ((m_cycle % WIN) == WIN - 1) begin
          good0.push_back(window_edges(0, m_cycle) >= MINE);
          good1.push_back(window_edges(1, m_cycle) >= MINE);
          m_ok0 = recent_all_good(0);
          m_ok1 = recent_all_good(1);
        end
        e.sel = m_sel;
        e.ok0 = m_ok0;
        e.ok1 = m_ok1;
        e.evt = evt;
        e.st  = (m_cycle < m_last_sw + HOLDOFF) ? 2'd2 : {1'b0, m_sel};
        exp_q.push_back(e);
        m_cycle++;
      end
    end
  end

  // Monitor: the DUT presents a fresh output set every cycle; compare it with
  // the oldest prediction half a period after the edge that produced it.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.sel_o, bus.clk0_ok_o, bus.clk1_ok_o, bus.switch_evt_o, bus.state_o};
        check_output("outputs", a, e);
      end
    end
  end

  task automatic check_output(input string name, input exp_t act, input exp_t req);
    num_checks++;
    if (act !== req) begin
      num_errors++;
      $display("[TB] FAIL %s t=%0t got sel=%b ok0=%b ok1=%b evt=%b st=%0d expected sel=%b ok0=%b ok1=%b evt=%b st=%0d",
               name, $time, act.sel, act.ok0, act.ok1, act.evt, act.st,
               req.sel, req.ok0, req.ok1, req.evt, req.st);
    end
  endtask

  task automatic set_toggle(input int c, input int mode, input int per);
    tgl_mode[c] = mode;
    tgl_per[c]  = per;
    tgl_ph[c]   = 0;
  endtask

  task automatic step_toggles();
    for (int c = 0; c < 2; c++) begin
      case (tgl_mode[c])
        1: begin
          tgl_ph[c]++;
          if (tgl_ph[c] >= tgl_per[c]) begin
            tgl_ph[c]  = 0;
            mon_tgl[c] = ~mon_tgl[c];
          end
        end
        2: begin
          if ($urandom_range(tgl_per[c] - 1, 0) == 0) mon_tgl[c] = ~mon_tgl[c];
        end
        default: ;
      endcase
    end
  endtask

  // Inputs change just after the falling edge, right after the monitor has
  // sampled, so the model and DUT see identical values at the rising edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      #1;
      step_toggles();
    end
  endtask

  task automatic apply_stimulus(input bit auto_en, input bit force_en, input bit force_sel);
    bus.auto_en_i   = auto_en;
    bus.force_en_i  = force_en;
    bus.force_sel_i = force_sel;
  endtask

  // One-cycle reset pulse; outputs must clear before any clock edge.
  task automatic pulse_reset();
    exp_t a;
    arst_i = 1'b1;
    #1;
    a = {bus.sel_o, bus.clk0_ok_o, bus.clk1_ok_o, bus.switch_evt_o, bus.state_o};
    check_output("async_reset", a, '0);
    run_cycles(1);
    arst_i = 1'b0;
  endtask

  initial begin
    arst_i  = 1'b1;
    mon_tgl = 2'b00;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    set_toggle(0, 0, 1);
    set_toggle(1, 0, 1);
    run_cycles(3);
    arst_i = 1'b0;

    $display("[TB] qualification with both clocks toggling");
    set_toggle(0, 1, 4);
    set_toggle(1, 1, 4);
    run_cycles(160);

    $display("[TB] clock 0 stops with auto failover enabled");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    set_toggle(0, 0, 1);
    run_cycles(250);

    $display("[TB] clock 0 recovers, no revert expected");
    set_toggle(0, 1, 4);
    run_cycles(200);

    $display("[TB] force requests, including one pending across HOLD");
    apply_stimulus(1'b1, 1'b1, 1'b1);
    run_cycles(10);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    run_cycles(30);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    run_cycles(5);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    run_cycles(30);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] edge count threshold");
    set_toggle(0, 1, 8);
    set_toggle(1, 1, 8);
    run_cycles(200);
    set_toggle(0, 1, 9);
    run_cycles(150);
    set_toggle(0, 2, 8);
    set_toggle(1, 2, 8);
    run_cycles(400);

    $display("[TB] reset in the middle of HOLD");
    set_toggle(0, 1, 4);
    set_toggle(1, 1, 4);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    run_cycles(5);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    pulse_reset();
    run_cycles(200);

    $display("[TB] randomized segments");
    for (int s = 0; s < 40; s++) begin
      for (int c = 0; c < 2; c++) begin
        case ($urandom_range(5, 0))
          0:       set_toggle(c, 0, 1);
          1, 2:    set_toggle(c, 1, $urandom_range(10, 3));
          default: set_toggle(c, 2, $urandom_range(12, 4));
        endcase
      end
      apply_stimulus($urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0,
                     $urandom_range(1, 0) == 1);
      run_cycles($urandom_range(300, 40));
      if ($urandom_range(19, 0) == 0) pulse_reset();
    end

    run_cycles(2);
    num_checks++;
    if (exp_q.size() > 1) begin
      num_errors++;
      $display("[TB] FAIL queue_drain pending=%0d expected at most 1", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/clk_fail_monitor.md
Name: clk_fail_monitor

Overview:
- Watchdog and failover controller that generates the registered clock-select bit driving the glitch-free clock mux stage directly downstream.
- Runs on a free-running reference clock.
- Measures the activity of the two candidate clocks through toggle signals, which are divide-by-2 flops inside each monitored domain, and declares each clock ok or failed.
- Selects clock 1 when clock 0 fails (auto mode) or per a software force; after every switch it holds the selection stable for a holdoff period.

Parameters:
- WIN_CYCLES, 1024: measurement window length in clk_i cycles (>=4).
- MIN_EDGES, 16: minimum toggle edges per window for a window to count as good.
- LOCK_WINDOWS, 4: consecutive good windows required before a clock's ok flag is raised.
- HOLDOFF, 256: clk_i cycles after a switch during which all requests are ignored (>=1).
- CNT_W, 16: width of the edge, window and holdoff counters; must hold WIN_CYCLES and HOLDOFF.

Ports:
- clk_i  in  1  free-running reference clock.
- arst_i  in  1  asynchronous reset, active-high.
- mon0_tgl_i  in  1  toggle from clock-0 domain; asynchronous to clk_i.
- mon1_tgl_i  in  1  toggle from clock-1 domain; asynchronous to clk_i.
- auto_en_i  in  1  enables automatic failover.
- force_en_i  in  1  force mode; has priority over auto.
- force_sel_i  in  1  forced selection, 0 = clock 0, 1 = clock 1.
- sel_o  out  1  registered select to the mux stage; 1 = clock 1.
- clk0_ok_o  out  1  clock 0 judged healthy.
- clk1_ok_o  out  1  clock 1 judged healthy.
- switch_evt_o  out  1  one-cycle pulse, asserted in the same cycle sel_o changes.
- state_o  out  2  FSM state: 0 USE0, 1 USE1, 2 HOLD.

Behaviour:
- Reset (async assert, sync release): sel_o=0, clk0_ok_o=0, clk1_ok_o=0, switch_evt_o=0, state_o=0 (USE0); all counters cleared; sync flops cleared.
- Synchronisation:
  - Each mon*_tgl_i passes through a 2-FF synchroniser plus one delay flop.
  - Edge = stage2 XOR stage3, so both toggle transitions count.
  - Latency from input transition to counted edge: 3 clk_i cycles.
- Window counter: counts 0..WIN_CYCLES-1 and wraps. The terminal count cycle is the window boundary.
- Edge counters (one per clock):
  - Increment on each edge and saturate at 2^CNT_W-1.
  - At the boundary the final value, including any edge in the boundary cycle, is compared against MIN_EDGES: >= is good, < is bad.
  - The counter then reloads to 0; an edge in the boundary cycle is not counted twice.
- Ok flags (per clock):
  - A bad window clears ok in the cycle after the boundary and resets the good-streak counter.
  - A good window increments the streak, which saturates at LOCK_WINDOWS.
  - ok is set in the cycle after the boundary at which the streak reaches LOCK_WINDOWS.
- FSM (evaluated every cycle; a "switch" sets sel_o=target, pulses switch_evt_o, loads holdoff=HOLDOFF and enters HOLD, all in one registered update):
  - USE0:
    - If force_en_i=1 and force_sel_i=1: switch to 1.
    - Else if force_en_i=0, auto_en_i=1, clk0_ok_o=0 and clk1_ok_o=1: switch to 1.
    - Otherwise stay.
  - USE1:
    - If force_en_i=1 and force_sel_i=0: switch to 0.
    - Else if force_en_i=0, auto_en_i=1, clk1_ok_o=0 and clk0_ok_o=1: switch to 0.
    - Otherwise stay. There is no auto-revert to clock 0 while clock 1 is ok.
  - HOLD:
    - Decrement holdoff; all force and auto requests are ignored.
    - When holdoff reaches 0, go to USE0 if sel_o=0, else USE1. sel_o stays unchanged through HOLD.
- Boundary conditions:
  - Both clocks bad: no switch; selection is held.
  - Force equal to the current selection: no switch, no pulse.
  - A force request still pending when HOLD exits is acted on in the first cycle of USE0/USE1.
  - Reset mid-HOLD or mid-window: returns immediately to reset values; ok flags must re-qualify from scratch.
  - Toggle input held static: 0 edges per window, so the window is bad.

Test Plan:
Bench parameters: WIN_CYCLES=64, MIN_EDGES=8, LOCK_WINDOWS=2, HOLDOFF=16, CNT_W=8.
1. Both toggles at 1 edge per 4 clk_i cycles (16 per window) from reset -> clk0_ok_o and clk1_ok_o rise the cycle after the 2nd window boundary (cycle 129); sel_o stays 0; switch_evt_o never pulses.
2. After (1), auto_en_i=1, stop mon0_tgl_i -> the next complete bad window drops clk0_ok_o; 1 cycle later sel_o=1, switch_evt_o pulses once, state_o=2 for 16 cycles, then state_o=1.
3. After (2), restart mon0_tgl_i -> clk0_ok_o rises after 2 good windows; sel_o remains 1 (no auto-revert).
4. In USE1, force_en_i=1, force_sel_i=0 asserted 5 cycles into HOLD -> no change during HOLD; at HOLD exit, sel_o=0 in the first USE cycle with a single switch_evt_o pulse.
5. Toggle rate giving exactly 8 edges per window -> windows good, ok=1; 7 edges per window -> ok=0 after the first such window.
6. Assert arst_i for 1 cycle mid-HOLD with sel_o=1 -> sel_o=0, state_o=0, both ok=0 immediately; ok flags re-qualify only after 2 new good windows.
